// File: rtl/blas_block_serializer_if.sv
// Handshake bundle for the block serializer: a wide block input on the
// producer side and a beat stream on the consumer side.
interface blas_block_serializer_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int BEATS  = 4
);
  localparam int BEAT_W = DATA_W * LANES;
  localparam int BLK_W  = BEAT_W * BEATS;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BLK_W-1:0]  blk_in;
  logic              blk_valid;
  logic              blk_ready;
  logic [BEAT_W-1:0] beat_out;
  logic              beat_valid;
  logic              beat_ready;
  logic [IDX_W-1:0]  beat_idx;
  logic              beat_last;

  // The side that produces blocks and consumes beats.
  modport master (
    output blk_in, blk_valid, beat_ready,
    input  blk_ready, beat_out, beat_valid, beat_idx, beat_last
  );

  // The serializer itself.
  modport slave (
    input  blk_in, blk_valid, beat_ready,
    output blk_ready, beat_out, beat_valid, beat_idx, beat_last
  );
endinterface

// File: rtl/blas_block_serializer.sv
// Breaks a wide result block into BEATS narrow beats of LANES elements.
// One block is sent from the active register while a second one can wait
// in a one-deep pending register; anything arriving while pending is full
// is dropped and counted, since the producer cannot be stalled.
module blas_block_serializer #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int BEATS  = 4
) (
  input  logic                    ref_clk,
  input  logic                    rst_n,
  blas_block_serializer_if.slave  bus,
  output logic                    overflow_err,
  output logic [7:0]              drop_cnt
);
  localparam int BEAT_W = DATA_W * LANES;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef logic [BEATS-1:0][BEAT_W-1:0] block_t;

  state_t            state_q, state_d;
  block_t            active_q, active_d;
  block_t            pending_q, pending_d;
  logic              pending_valid_q, pending_valid_d;
  logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic accept;
  logic drop;
  logic handshake;
  logic accept_used;

  assign bus.blk_ready  = !pending_valid_q;
  assign accept         = bus.blk_valid && !pending_valid_q;
  assign drop           = bus.blk_valid && pending_valid_q;
  assign handshake      = (state_q == SEND) && bus.beat_ready;

  assign bus.beat_valid = (state_q == SEND);
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_last  = (state_q == SEND) && (beat_idx_q == LAST_IDX);
  assign bus.beat_out   = (state_q == SEND) ? active_q[beat_idx_q] : '0;
  assign overflow_err   = overflow_q;
  assign drop_cnt       = drop_cnt_q;

  // State register: every piece of state reloads from its next value, reset clears all.
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      beat_idx_q      <= '0;
      overflow_q      <= 1'b0;
      drop_cnt_q      <= 8'd0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      beat_idx_q      <= beat_idx_d;
      overflow_q      <= overflow_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  // Next-state logic: advance beats, refill active from pending or input, buffer or drop arrivals.
  always_comb begin
    state_d         = state_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    beat_idx_d      = beat_idx_q;
    overflow_d      = overflow_q;
    drop_cnt_d      = drop_cnt_q;
    accept_used     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          active_d    = bus.blk_in;
          beat_idx_d  = '0;
          state_d     = SEND;
          accept_used = 1'b1;
        end
      end
      SEND: begin
        if (handshake) begin
          if (beat_idx_q != LAST_IDX) begin
            beat_idx_d = beat_idx_q + 1'b1;
          end else if (pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
            beat_idx_d      = '0;
          end else if (accept) begin
            active_d    = bus.blk_in;
            beat_idx_d  = '0;
            accept_used = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        if (accept && !accept_used) begin
          pending_d       = bus.blk_in;
          pending_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_blas_block_serializer.sv
// Bench for the block serializer: directed scenarios followed by random
// traffic, all compared each cycle against a queue-of-blocks reference model.
module tb_blas_block_serializer;
  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int BEATS  = 4;
  localparam int BEAT_W = DATA_W * LANES;
  localparam int BLK_W  = BEAT_W * BEATS;

  typedef logic [BLK_W-1:0] blk_t;

  logic       ref_clk;
  logic       rst_n;
  logic       overflow_err;
  logic [7:0] drop_cnt;

  blas_block_serializer_if #(.DATA_W(DATA_W), .LANES(LANES), .BEATS(BEATS)) blk_bus ();

  blas_block_serializer #(.DATA_W(DATA_W), .LANES(LANES), .BEATS(BEATS)) dut (
    .ref_clk      (ref_clk),
    .rst_n        (rst_n),
    .bus          (blk_bus),
    .overflow_err (overflow_err),
    .drop_cnt     (drop_cnt)
  );

  // Free-running clock.
  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  int   checks = 0;
  int   errors = 0;

  blk_t model_q[$];
  int   model_sent = 0;
  int   model_drops = 0;
  bit   model_ovf = 1'b0;
  bit   model_after_reset = 1'b0;

  function automatic blk_t mk_block(input logic [31:0] base);
    blk_t b;
    for (int i = 0; i < LANES * BEATS; i++) b[32*i +: 32] = base + 32'(i);
    return b;
  endfunction

  function automatic blk_t rand_block();
    blk_t b;
    for (int i = 0; i < LANES * BEATS; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    logic [127:0] exp_beat;
    blk_t         front;
    bit           exp_valid;
    exp_valid = (model_q.size() > 0);
    chk("beat_valid", 128'(blk_bus.beat_valid), 128'(exp_valid));
    chk("blk_ready", 128'(blk_bus.blk_ready), 128'(model_q.size() < 2));
    chk("overflow_err", 128'(overflow_err), 128'(model_ovf));
    chk("drop_cnt", 128'(drop_cnt), 128'(model_drops));
    chk("beat_last", 128'(blk_bus.beat_last), 128'(exp_valid && model_sent == BEATS - 1));
    if (exp_valid) begin
      front = model_q[0];
      exp_beat = '0;
      for (int a = 0; a < LANES; a++) exp_beat[32*a +: 32] = front[32*(LANES*model_sent + a) +: 32];
      chk("beat_out", blk_bus.beat_out, exp_beat);
      chk("beat_idx", 128'(blk_bus.beat_idx), 128'(model_sent));
    end
    if (model_after_reset) begin
      chk("reset_beat_out", blk_bus.beat_out, 128'd0);
      chk("reset_beat_idx", 128'(blk_bus.beat_idx), 128'd0);
    end
  endtask

  task automatic updateModel(input bit rstn, input bit bv, input blk_t blk, input bit br);
    bit can_take;
    if (!rstn) begin
      model_q.delete();
      model_sent = 0;
      model_drops = 0;
      model_ovf = 1'b0;
      model_after_reset = 1'b1;
      return;
    end
    model_after_reset = 1'b0;
    can_take = (model_q.size() < 2);
    if (model_q.size() > 0 && br) begin
      model_sent++;
      if (model_sent == BEATS) begin
        void'(model_q.pop_front());
        model_sent = 0;
      end
    end
    if (bv && can_take) begin
      model_q.push_back(blk);
    end else if (bv) begin
      model_ovf = 1'b1;
      if (model_drops < 255) model_drops++;
    end
  endtask

  task automatic applyStimulus(input bit rstn, input bit bv, input blk_t blk, input bit br);
    @(negedge ref_clk);
    rst_n             = rstn;
    blk_bus.blk_valid = bv;
    blk_bus.blk_in    = blk;
    blk_bus.beat_ready = br;
    checkOutput();
    @(posedge ref_clk);
    updateModel(rstn, bv, blk, br);
  endtask

  // Directed scenarios, then random traffic, then the summary.
  initial begin
    blk_t b1, b2, b3;
    logic [127:0] exp_first;
    rst_n = 1'b0;
    blk_bus.blk_valid  = 1'b0;
    blk_bus.blk_in     = '0;
    blk_bus.beat_ready = 1'b0;
    @(posedge ref_clk);
    updateModel(1'b0, 1'b0, '0, 1'b0);

    $display("[TB] reset with blk_valid asserted");
    applyStimulus(1'b0, 1'b1, rand_block(), 1'b0);
    applyStimulus(1'b0, 1'b1, rand_block(), 1'b1);

    $display("[TB] single block");
    b1 = mk_block(32'h1000);
    applyStimulus(1'b1, 1'b1, b1, 1'b1);
    #1;
    chk("single_beat0", blk_bus.beat_out, 128'h00001003_00001002_00001001_00001000);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);

    $display("[TB] backpressure on beat 1");
    b1 = mk_block(32'h2000);
    applyStimulus(1'b1, 1'b1, b1, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    #1;
    chk("bp_idx_held", 128'(blk_bus.beat_idx), 128'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);

    $display("[TB] two pulses two cycles apart");
    b1 = mk_block(32'h3000);
    b2 = mk_block(32'h4000);
    applyStimulus(1'b1, 1'b1, b1, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, b2, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);

    $display("[TB] overflow and drop counter saturation");
    applyStimulus(1'b1, 1'b1, mk_block(32'h5000), 1'b0);
    applyStimulus(1'b1, 1'b1, mk_block(32'h6000), 1'b0);
    applyStimulus(1'b1, 1'b1, mk_block(32'h7000), 1'b0);
    #1;
    chk("first_drop_cnt", 128'(drop_cnt), 128'd1);
    chk("first_drop_ovf", 128'(overflow_err), 128'd1);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, rand_block(), 1'b0);
    #1;
    chk("drop_saturated", 128'(drop_cnt), 128'd255);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);

    $display("[TB] new block on last-beat handshake");
    b1 = mk_block(32'h8000);
    b2 = mk_block(32'h9000);
    applyStimulus(1'b1, 1'b1, b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, b2, 1'b1);
    #1;
    exp_first = b2[127:0];
    chk("zero_bubble_idx", 128'(blk_bus.beat_idx), 128'd0);
    chk("zero_bubble_beat", blk_bus.beat_out, exp_first);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);

    $display("[TB] reset during beat 2 with pending full");
    b1 = mk_block(32'hA000);
    b2 = mk_block(32'hB000);
    b3 = mk_block(32'hC000);
    applyStimulus(1'b1, 1'b1, b1, 1'b0);
    applyStimulus(1'b1, 1'b1, b2, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, b3, 1'b1);
    #1;
    chk("mid_reset_valid", 128'(blk_bus.beat_valid), 128'd0);
    chk("mid_reset_ready", 128'(blk_bus.blk_ready), 128'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 99) < 30),
                    rand_block(),
                    ($urandom_range(0, 99) < 60));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
